// File: rtl/gfx_mem_pkg.sv
// Shared types and host address map for the graphics memory port-1 arbiter.
// The decode turns a unified host word address into {hit, memory, local address}.
package gfx_mem_pkg;

    typedef enum logic [2:0] {
        MEM_TB  = 3'd0,
        MEM_TG  = 3'd1,
        MEM_SG  = 3'd2,
        MEM_PAL = 3'd3,
        MEM_OAM = 3'd4
    } mem_idx_e;

    localparam int NUM_MEMS = 5;

    localparam logic [15:0] TB_BASE  = 16'h0000, TB_SIZE  = 16'h012C;
    localparam logic [15:0] OAM_BASE = 16'h0200, OAM_SIZE = 16'h0100;
    localparam logic [15:0] PAL_BASE = 16'h0300, PAL_SIZE = 16'h0008;
    localparam logic [15:0] TG_BASE  = 16'h0800, TG_SIZE  = 16'h0800;
    localparam logic [15:0] SG_BASE  = 16'h1000, SG_SIZE  = 16'h0800;

    typedef struct packed {
        mem_idx_e    idx;
        logic [10:0] addr;
        logic [31:0] data;
    } wr_entry_t;

    typedef struct packed {
        logic        hit;
        mem_idx_e    idx;
        logic [10:0] addr;
    } dec_t;

    // Offset wraps to a large value below base, so one compare covers both bounds.
    function automatic logic in_range(input logic [15:0] a, input logic [15:0] base,
                                      input logic [15:0] size);
        logic [15:0] off;
        off = a - base;
        return off < size;
    endfunction

    function automatic logic [10:0] local_addr(input logic [15:0] a, input logic [15:0] base);
        logic [15:0] off;
        off = a - base;
        return off[10:0];
    endfunction

    function automatic dec_t decode(input logic [15:0] a);
        dec_t d;
        d = '{hit: 1'b0, idx: MEM_TB, addr: 11'd0};
        if (in_range(a, TB_BASE, TB_SIZE))
            d = '{hit: 1'b1, idx: MEM_TB, addr: local_addr(a, TB_BASE)};
        else if (in_range(a, OAM_BASE, OAM_SIZE))
            d = '{hit: 1'b1, idx: MEM_OAM, addr: local_addr(a, OAM_BASE)};
        else if (in_range(a, PAL_BASE, PAL_SIZE))
            d = '{hit: 1'b1, idx: MEM_PAL, addr: local_addr(a, PAL_BASE)};
        else if (in_range(a, TG_BASE, TG_SIZE))
            d = '{hit: 1'b1, idx: MEM_TG, addr: local_addr(a, TG_BASE)};
        else if (in_range(a, SG_BASE, SG_SIZE))
            d = '{hit: 1'b1, idx: MEM_SG, addr: local_addr(a, SG_BASE)};
        return d;
    endfunction

endpackage

// File: rtl/host_wfifo.sv
// Synchronous FIFO for decoded host writes; push is ignored when full, pop when empty.
// Power-of-two DEPTH lets the pointers wrap naturally.
module host_wfifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/gfx_vram_arbiter.sv
// Shares port 1 of the five graphics memories between buffered host writes and renderer
// reads: renderer first during active video, host first during blanking.
module gfx_vram_arbiter
    import gfx_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int HADDR_W    = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               blank,
    input  logic               host_valid,
    output logic               host_ready,
    input  logic [HADDR_W-1:0] host_addr,
    input  logic [31:0]        host_wdata,
    output logic               host_err,
    input  logic               rend_req,
    input  logic [2:0]         rend_sel,
    input  logic [10:0]        rend_addr,
    output logic               rend_grant,
    output logic               rend_rvalid,
    output logic [2:0]         rend_rsel,
    output logic [4:0]         m_we,
    output logic [10:0]        m_addr,
    output logic [31:0]        m_wdata
);
    dec_t      dec;
    wr_entry_t push_entry, head;
    logic      fifo_full, fifo_empty;
    logic      accept, push, pop;

    logic            blank_q;
    logic [4:0]      m_we_q, m_we_d;
    logic [10:0]     m_addr_q, m_addr_d;
    logic [31:0]     m_wdata_q, m_wdata_d;
    logic            host_err_q, host_err_d;
    logic [1:0]      vld_pipe_q, vld_pipe_d;
    logic [1:0][2:0] rsel_pipe_q, rsel_pipe_d;

    host_wfifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(wr_entry_t))
    ) u_wfifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign host_ready = ~fifo_full;
    assign rend_grant = rst_n & rend_req & (~blank_q | fifo_empty);

    always_comb begin
        dec        = decode(16'(host_addr));
        accept     = host_valid & host_ready;
        push       = accept & dec.hit;
        push_entry = '{idx: dec.idx, addr: dec.addr, data: host_wdata};
        host_err_d = accept & ~dec.hit;
        // The FIFO takes every cycle the renderer does not.
        pop        = ~fifo_empty & (blank_q | ~rend_req);

        m_we_d    = '0;
        m_addr_d  = rend_addr;
        m_wdata_d = m_wdata_q;
        if (pop) begin
            m_we_d    = 5'b00001 << head.idx;
            m_addr_d  = head.addr;
            m_wdata_d = head.data;
        end

        vld_pipe_d  = {vld_pipe_q[0], rend_grant};
        rsel_pipe_d = {rsel_pipe_q[0], rend_sel};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q     <= 1'b0;
            m_we_q      <= '0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            host_err_q  <= 1'b0;
            vld_pipe_q  <= '0;
            rsel_pipe_q <= '0;
        end else begin
            blank_q     <= blank;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            host_err_q  <= host_err_d;
            vld_pipe_q  <= vld_pipe_d;
            rsel_pipe_q <= rsel_pipe_d;
        end
    end

    assign m_we        = m_we_q;
    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
    assign host_err    = host_err_q;
    assign rend_rvalid = vld_pipe_q[1];
    assign rend_rsel   = rsel_pipe_q[1];

endmodule

// File: tb/tb_gfx_vram_arbiter.sv
// Bench for gfx_vram_arbiter: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_gfx_vram_arbiter;
    localparam int FIFO_DEPTH = 4;
    localparam int HADDR_W    = 13;

    // Address map indexed by memory number (tile buf, tile gfx, sprite gfx, palette, OAM).
    localparam int MB [5] = '{'h0000, 'h0800, 'h1000, 'h0300, 'h0200};
    localparam int MS [5] = '{'h012C, 'h0800, 'h0800, 'h0008, 'h0100};

    logic               clk = 1'b0;
    logic               rst_n;
    logic               blank;
    logic               host_valid;
    logic               host_ready;
    logic [HADDR_W-1:0] host_addr;
    logic [31:0]        host_wdata;
    logic               host_err;
    logic               rend_req;
    logic [2:0]         rend_sel;
    logic [10:0]        rend_addr;
    logic               rend_grant;
    logic               rend_rvalid;
    logic [2:0]         rend_rsel;
    logic [4:0]         m_we;
    logic [10:0]        m_addr;
    logic [31:0]        m_wdata;

    int checks = 0;
    int errors = 0;

    gfx_vram_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .HADDR_W(HADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .blank       (blank),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_err    (host_err),
        .rend_req    (rend_req),
        .rend_sel    (rend_sel),
        .rend_addr   (rend_addr),
        .rend_grant  (rend_grant),
        .rend_rvalid (rend_rvalid),
        .rend_rsel   (rend_rsel),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          idx;
        int          addr;
        logic [31:0] data;
    } mw_t;

    mw_t         mq[$];
    bit          mblank = 0;
    logic [4:0]  e_we = '0;
    int          e_addr = 0;
    logic [31:0] e_wdata = '0;
    bit          e_rd = 0, e_err = 0, e_rv = 0, p_rv = 0;
    logic [2:0]  e_rsel = '0, p_rsel = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mblank = 0; e_we = '0; e_addr = 0; e_wdata = '0; e_rd = 0; e_err = 0;
            e_rv = 0; p_rv = 0; e_rsel = '0; p_rsel = '0;
        end else begin
            bit  g, take_host, hit;
            int  n, idx, loc;
            mw_t w;
            n = mq.size();
            // Active video: renderer always served, host only in idle renderer cycles.
            // Blanking: host served while it has data, renderer only when host is empty.
            if (mblank) begin
                take_host = (n != 0);
                g         = rend_req && !take_host;
            end else begin
                g         = rend_req;
                take_host = (n != 0) && !rend_req;
            end
            e_we = '0;
            e_rd = g;
            if (take_host) begin
                w       = mq.pop_front();
                e_we    = 5'b00001 << w.idx;
                e_addr  = w.addr;
                e_wdata = w.data;
            end else if (g) begin
                e_addr = int'(rend_addr);
            end
            e_err = 0;
            if (host_valid && n < FIFO_DEPTH) begin
                hit = 0; idx = 0; loc = 0;
                for (int k = 0; k < 5; k++)
                    if (int'(host_addr) >= MB[k] && int'(host_addr) < MB[k] + MS[k]) begin
                        hit = 1; idx = k; loc = int'(host_addr) - MB[k];
                    end
                if (hit) mq.push_back('{idx, loc, host_wdata});
                else     e_err = 1;
            end
            e_rv   = p_rv;
            e_rsel = p_rsel;
            p_rv   = g;
            p_rsel = rend_sel;
            mblank = blank;
        end
    end

    always @(negedge clk) begin
        chk("m_we", 64'(m_we), 64'(e_we));
        if (e_we != 0 || e_rd) chk("m_addr", 64'(m_addr), 64'(e_addr));
        if (e_we != 0) chk("m_wdata", 64'(m_wdata), 64'(e_wdata));
        chk("rend_rvalid", 64'(rend_rvalid), 64'(e_rv));
        if (e_rv) chk("rend_rsel", 64'(rend_rsel), 64'(e_rsel));
        chk("host_err", 64'(host_err), 64'(e_err));
        chk("host_ready", 64'(host_ready), 64'(mq.size() < FIFO_DEPTH));
        chk("rend_grant", 64'(rend_grant),
            64'(rst_n && rend_req && (!mblank || mq.size() == 0)));
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wr_chk(input logic [12:0] a, input logic [31:0] d,
                          input logic [4:0] we, input logic [10:0] la);
        host_valid = 1'b1; host_addr = a; host_wdata = d;
        #1 chk("wr_ready", 64'(host_ready), 64'd1);
        cyc(); host_valid = 1'b0;
        cyc(); #1;
        chk("wr_we", 64'(m_we), 64'(we));
        chk("wr_addr", 64'(m_addr), 64'(la));
        chk("wr_data", 64'(m_wdata), 64'(d));
        cyc(); #1 chk("wr_we_pulse", 64'(m_we), 64'd0);
    endtask

    task automatic err_chk(input logic [12:0] a);
        host_valid = 1'b1; host_addr = a; host_wdata = 32'h5555_AAAA;
        cyc(); host_valid = 1'b0;
        #1;
        chk("err_pulse", 64'(host_err), 64'd1);
        chk("err_no_we", 64'(m_we), 64'd0);
        cyc(); #1;
        chk("err_clear", 64'(host_err), 64'd0);
        chk("err_no_we2", 64'(m_we), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1; blank = 1'b0; host_valid = 1'b0; host_addr = '0; host_wdata = '0;
        rend_req = 1'b1; rend_sel = '0; rend_addr = '0;
        #1 rst_n = 1'b0;
        repeat (2) cyc();
        #1;
        chk("rst_m_we", 64'(m_we), 64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        chk("rst_m_wdata", 64'(m_wdata), 64'd0);
        chk("rst_rvalid", 64'(rend_rvalid), 64'd0);
        chk("rst_rsel", 64'(rend_rsel), 64'd0);
        chk("rst_err", 64'(host_err), 64'd0);
        chk("rst_ready", 64'(host_ready), 64'd1);
        chk("rst_grant_forced", 64'(rend_grant), 64'd0);
        rend_req = 1'b0;
        #1 rst_n = 1'b1;

        // Blanking writes and address decode
        blank = 1'b1;
        cyc(); cyc();
        wr_chk(13'h0005, 32'hDEADBEEF, 5'b00001, 11'h005);
        wr_chk(13'h0307, 32'h00FF8800, 5'b01000, 11'h007);
        wr_chk(13'h02FF, 32'h0000_1234, 5'b10000, 11'h0FF);
        wr_chk(13'h0FFF, 32'hCAFE_0001, 5'b00010, 11'h7FF);
        wr_chk(13'h1000, 32'hCAFE_0002, 5'b00100, 11'h000);
        err_chk(13'h012C);
        err_chk(13'h1800);
        err_chk(13'h0400);

        // Unused select still returns rvalid without a write
        rend_req = 1'b1; rend_sel = 3'd6; rend_addr = 11'h003;
        #1 chk("sel6_grant", 64'(rend_grant), 64'd1);
        cyc(); rend_req = 1'b0;
        cyc(); #1;
        chk("sel6_rvalid", 64'(rend_rvalid), 64'd1);
        chk("sel6_rsel", 64'(rend_rsel), 64'd6);
        chk("sel6_no_we", 64'(m_we), 64'd0);
        cyc(); #1 chk("sel6_rvalid_off", 64'(rend_rvalid), 64'd0);

        // FIFO fills during active video, drains in order once the renderer idles
        blank = 1'b0;
        cyc(); cyc();
        rend_req = 1'b1; rend_sel = 3'd1; rend_addr = 11'h020;
        for (int i = 0; i < 5; i++) begin
            host_valid = 1'b1; host_addr = 13'h0010 + 13'(i); host_wdata = 32'hA0 + 32'(i);
            #1 chk("t3_ready", 64'(host_ready), 64'(i < 4));
            if (i < 4) cyc();
        end
        repeat (2) begin
            cyc(); #1;
            chk("t3_stall_ready", 64'(host_ready), 64'd0);
            chk("t3_stall_we", 64'(m_we), 64'd0);
        end
        rend_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (k == 1) host_valid = 1'b0;
            #1;
            chk("t3_we", 64'(m_we), 64'd1);
            chk("t3_addr", 64'(m_addr), 64'h10 + 64'(k));
            chk("t3_data", 64'(m_wdata), 64'hA0 + 64'(k));
        end
        cyc(); #1 chk("t3_done", 64'(m_we), 64'd0);

        // Host priority in blanking
        rend_req = 1'b1; rend_sel = 3'd2; rend_addr = 11'h005;
        host_valid = 1'b1; host_addr = 13'h0300; host_wdata = 32'h1;
        cyc(); host_addr = 13'h0301; host_wdata = 32'h2;
        cyc(); host_valid = 1'b0;
        blank = 1'b1;
        #1 chk("t4_grant_pre", 64'(rend_grant), 64'd1);
        cyc(); rend_sel = 3'd4; rend_addr = 11'h010;
        #1 chk("t4_grant0", 64'(rend_grant), 64'd0);
        cyc(); #1 chk("t4_grant1", 64'(rend_grant), 64'd0);
        cyc(); #1 chk("t4_grant2", 64'(rend_grant), 64'd1);
        cyc(); rend_req = 1'b0;
        #1;
        chk("t4_raddr", 64'(m_addr), 64'h10);
        chk("t4_no_we", 64'(m_we), 64'd0);
        cyc(); #1;
        chk("t4_rvalid", 64'(rend_rvalid), 64'd1);
        chk("t4_rsel", 64'(rend_rsel), 64'd4);

        // blank rises with a full FIFO and a pending read
        blank = 1'b0; rend_req = 1'b1; rend_sel = 3'd0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            host_valid = 1'b1; host_addr = 13'h0800 + 13'(i); host_wdata = 32'hB0 + 32'(i);
            cyc();
        end
        host_valid = 1'b0;
        blank = 1'b1;
        #1;
        chk("t5_full", 64'(host_ready), 64'd0);
        chk("t5_grant_n", 64'(rend_grant), 64'd1);
        cyc(); #1 chk("t5_grant_n1", 64'(rend_grant), 64'd0);
        cyc(); #1;
        chk("t5_we", 64'(m_we), 64'b00010);
        chk("t5_addr", 64'(m_addr), 64'd0);
        rend_req = 1'b0;
        repeat (6) cyc();

        // Reset with queued writes and reads in flight
        blank = 1'b0;
        cyc(); cyc();
        rend_req = 1'b1; rend_sel = 3'd3;
        for (int i = 0; i < 3; i++) begin
            host_valid = 1'b1; host_addr = 13'h1000 + 13'(i); host_wdata = 32'hC0 + 32'(i);
            cyc();
        end
        host_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_we", 64'(m_we), 64'd0);
        chk("t6_rvalid", 64'(rend_rvalid), 64'd0);
        chk("t6_grant", 64'(rend_grant), 64'd0);
        rend_req = 1'b0; blank = 1'b1;
        cyc(); cyc();
        #1 rst_n = 1'b1;
        repeat (4) begin
            cyc(); #1;
            chk("t6_ready", 64'(host_ready), 64'd1);
            chk("t6_no_stale", 64'(m_we), 64'd0);
        end

        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
